pipo_load_arbiter: RTL and testbench

Round-robin arbiter that shares a single parallel-in/parallel-out register between several requesters. Each requester presents a data word and raises a request. The arbiter grants one requester at a time and drives the register's `ld`/`pin` inputs for exactly one cycle. It then holds ownership for a programmable guard period and acknowledges the winner once the register output is valid. It sits directly in front of the `pipo` register instance; the register's `rst` is driven by the system reset, not by this block.

---
 rtl/pipo_load_arbiter.sv | 132 +++++++++++++
 tb/tb_pipo_load_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter
// Round-robin arbiter that shares one parallel-in/parallel-out register
// among NREQ requesters. In IDLE it picks a winner and registers that
// requester's data word onto pin with a one-cycle ld strobe. The winner
// then keeps ownership for HOLD_CYC guard cycles, and it is acknowledged
// once the register output holds its word.
//
// Ports:
//   clk    in   1            rising-edge clock
//   rst    in   1            asynchronous active-high reset
//   req    in   NREQ         per-requester request level
//   din    in   NREQ*WIDTH   requester data, slice i at [i*WIDTH +: WIDTH]
//   ld     out  1            load strobe to the shared register
//   pin    out  WIDTH        registered data to the shared register
//   gnt    out  NREQ         one-hot grant, zero when idle
//   ack    out  NREQ         one-hot pulse: winner's data is on the register output
//   busy   out  1            high whenever the FSM is not in IDLE
//   owner  out  IDXW         index of the current or most recent winner
module pipo_load_arbiter #(
    parameter int WIDTH    = 4,
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 2,
    parameter int IDXW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic                  ld,
    output logic [WIDTH-1:0]      pin,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [IDXW-1:0]       owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [IDXW-1:0] rr_ptr;
    logic [3:0]      hold_cnt;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [WIDTH-1:0] win_data;
    logic [IDXW-1:0] next_ptr;
    int              probe;

    // Round-robin search: scan upward from rr_ptr and wrap modulo NREQ, so
    // NREQ does not have to be a power of two. The first set request wins.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        probe      = 0;
        for (int k = 0; k < NREQ; k++) begin
            probe = (int'(rr_ptr) + k) % NREQ;
            if (!win_found && req[probe]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(probe);
            end
        end
        win_onehot = '0;
        win_onehot[win_idx] = 1'b1;
        win_data   = din[int'(win_idx)*WIDTH +: WIDTH];
    end

    // The pointer moves to the slot just past the owner. The wrap is explicit
    // because NREQ may be smaller than 2**IDXW.
    always_comb begin
        if (owner == IDXW'(NREQ-1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = owner + IDXW'(1);
        end
    end

    // Single FSM with every output registered. gnt already holds one-hot(owner),
    // so GRANT copies it straight into ack. pin keeps its value everywhere
    // except at the IDLE->GRANT capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            ld       <= 1'b0;
            pin      <= '0;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            owner    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt   <= win_onehot;
                        owner <= win_idx;
                        pin   <= win_data;
                        ld    <= 1'b1;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    ld       <= 1'b0;
                    ack      <= gnt;
                    rr_ptr   <= next_ptr;
                    hold_cnt <= 4'(HOLD_CYC - 1);
                    state    <= HOLD;
                end
                HOLD: begin
                    ack <= '0;
                    if (hold_cnt == 4'd0) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// tb_pipo_load_arbiter
// Self-checking bench for pipo_load_arbiter. It builds two instances: one
// with the default guard period (HOLD_CYC=2) and one with HOLD_CYC=5.
// A transaction-level model predicts every output on every cycle. Directed
// scenarios pin the model with hand-computed literal expectations.
module tb_pipo_load_arbiter;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int IDXW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0]   req_a = '0;
    logic [N*W-1:0] din_a = '0;
    logic [N-1:0]   req_b = '0;
    logic [N*W-1:0] din_b = '0;

    logic           ld_a, ld_b;
    logic [W-1:0]   pin_a, pin_b;
    logic [N-1:0]   gnt_a, gnt_b, ack_a, ack_b;
    logic           busy_a, busy_b;
    logic [IDXW-1:0] owner_a, owner_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pipo_load_arbiter #(.WIDTH(W), .NREQ(N), .HOLD_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .din(din_a),
        .ld(ld_a), .pin(pin_a), .gnt(gnt_a), .ack(ack_a),
        .busy(busy_a), .owner(owner_a)
    );

    pipo_load_arbiter #(.WIDTH(W), .NREQ(N), .HOLD_CYC(5)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .din(din_b),
        .ld(ld_b), .pin(pin_b), .gnt(gnt_b), .ack(ack_b),
        .busy(busy_b), .owner(owner_b)
    );

    // Shared register fed by instance A. It is reset by the system reset.
    logic [W-1:0] pout = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) pout <= '0;
        else if (ld_a) pout <= pin_a;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model. A transaction is "active" for HOLD+1 cycles, and
    // m_t counts cycles since the load started: t=0 is the load cycle, t=1
    // is the acknowledge cycle. When no transaction is active, the requests
    // are scanned round-robin from m_ptr.
    int             hold_of [2] = '{2, 5};
    bit             m_act   [2];
    int             m_t     [2];
    int             m_ptr   [2];
    int             m_own   [2];
    logic [W-1:0]   m_pin   [2] = '{default: '0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            logic [N-1:0]   r;
            logic [N*W-1:0] d;
            bit             found;
            int             j;
            r = (i == 0) ? req_a : req_b;
            d = (i == 0) ? din_a : din_b;
            if (rst) begin
                m_act[i] = 0; m_t[i] = 0; m_ptr[i] = 0; m_own[i] = 0; m_pin[i] = '0;
            end else if (!m_act[i]) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr[i] + k) % N;
                    if (!found && r[j]) begin
                        found    = 1;
                        m_own[i] = j;
                        m_pin[i] = d[j*W +: W];
                    end
                end
                if (found) begin
                    m_act[i] = 1;
                    m_t[i]   = 0;
                end
            end else begin
                if (m_t[i] == 0) m_ptr[i] = (m_own[i] + 1) % N;
                m_t[i] = m_t[i] + 1;
                if (m_t[i] > hold_of[i]) m_act[i] = 0;
            end
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_inst(input int i, input logic ld, input logic [W-1:0] pin,
                                input logic [N-1:0] gnt, input logic [N-1:0] ack,
                                input logic busy, input logic [IDXW-1:0] owner);
        logic [N-1:0] oh;
        string        p;
        oh = '0;
        oh[m_own[i]] = 1'b1;
        p = (i == 0) ? "a" : "b";
        check_output({p, "_ld"},    int'(ld),    int'(m_act[i] && m_t[i] == 0));
        check_output({p, "_pin"},   int'(pin),   int'(m_pin[i]));
        check_output({p, "_gnt"},   int'(gnt),   m_act[i] ? int'(oh) : 0);
        check_output({p, "_ack"},   int'(ack),   (m_act[i] && m_t[i] == 1) ? int'(oh) : 0);
        check_output({p, "_busy"},  int'(busy),  int'(m_act[i]));
        check_output({p, "_owner"}, int'(owner), m_own[i]);
    endtask

    // Per-cycle comparison on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        compare_inst(0, ld_a, pin_a, gnt_a, ack_a, busy_a, owner_a);
        compare_inst(1, ld_b, pin_b, gnt_b, ack_b, busy_b, owner_b);
    end

    // Remembers any grant or ack ever given to requester 1 on instance A.
    bit seen1 = 0;
    always @(negedge clk) if (gnt_a[1] || ack_a[1]) seen1 = 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ld(input int i, output bit ok);
        ok = 0;
        for (int n = 0; n < 30 && !ok; n++) begin
            tick();
            ok = (i == 0) ? ld_a : ld_b;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wait_ld_%0d: actual=no load expected=load within 30 cycles", i);
        end
    endtask

    task automatic apply_stimulus(input logic [N-1:0] ra, input logic [N*W-1:0] da);
        req_a = ra;
        din_a = da;
    endtask

    initial begin
        bit ok;
        int last;
        int gcount;
        int exp_own [5] = '{0, 1, 2, 3, 0};

        req_b = 4'b0011;
        din_b = 16'h4321;
        repeat (3) tick();
        check_output("reset_ld",    int'(ld_a),    0);
        check_output("reset_pin",   int'(pin_a),   0);
        check_output("reset_gnt",   int'(gnt_a),   0);
        check_output("reset_busy",  int'(busy_a),  0);
        check_output("reset_owner", int'(owner_a), 0);
        rst = 1'b0;

        // Single request.
        apply_stimulus(4'b0001, 16'h000A);
        tick();
        check_output("single_ld",  int'(ld_a),  1);
        check_output("single_pin", int'(pin_a), 'hA);
        check_output("single_gnt", int'(gnt_a), 'h1);
        apply_stimulus(4'b0000, 16'h000A);
        tick();
        check_output("single_ack",  int'(ack_a), 'h1);
        check_output("single_pout", int'(pout),  'hA);
        check_output("single_ld_low", int'(ld_a), 0);
        tick();
        check_output("single_busy_hold", int'(busy_a), 1);
        tick();
        check_output("single_busy_done", int'(busy_a), 0);
        check_output("single_gnt_done",  int'(gnt_a),  0);

        // Everyone requesting after reset: strict rotation, 4 cycles apart.
        apply_stimulus(4'b1111, {4'b1000, 4'b0100, 4'b0010, 4'b0001});
        reset_pulse();
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ld(0, ok);
            check_output("rot_owner", int'(owner_a), exp_own[g]);
            check_output("rot_pin",   int'(pin_a),   1 << exp_own[g]);
            if (g > 0) check_output("rot_spacing", cyc - last, 4);
            last = cyc;
        end
        apply_stimulus(4'b0000, din_a);

        // Fairness: requester 0 always asking, requester 2 arrives during HOLD.
        reset_pulse();
        apply_stimulus(4'b0001, 16'h5A3C);
        wait_ld(0, ok);
        check_output("fair_first", int'(owner_a), 0);
        tick();
        apply_stimulus(4'b0101, 16'h5A3C);
        wait_ld(0, ok);
        check_output("fair_second", int'(owner_a), 2);
        check_output("fair_pin2",   int'(pin_a),   'hA);
        apply_stimulus(4'b0001, 16'h5A3C);
        wait_ld(0, ok);
        check_output("fair_third", int'(owner_a), 0);

        // Withdrawn request: req[1] lives only inside requester 0's HOLD.
        seen1 = 0;
        tick();
        apply_stimulus(4'b0011, 16'h5A3C);
        tick();
        apply_stimulus(4'b0001, 16'h5A3C);
        wait_ld(0, ok);
        check_output("withdrawn_owner", int'(owner_a), 0);
        wait_ld(0, ok);
        check_output("withdrawn_never", int'(seen1), 0);

        // Reset while ld is high: outputs drop at once and the pointer restarts.
        apply_stimulus(4'b0100, 16'h5A3C);
        wait_ld(0, ok);
        rst = 1'b1;
        #1;
        check_output("rstmid_ld",   int'(ld_a),   0);
        check_output("rstmid_gnt",  int'(gnt_a),  0);
        check_output("rstmid_pin",  int'(pin_a),  0);
        check_output("rstmid_busy", int'(busy_a), 0);
        apply_stimulus(4'b0110, 16'h5A3C);
        rst = 1'b0;
        wait_ld(0, ok);
        check_output("rstmid_next", int'(owner_a), 1);

        // Randomised traffic on both instances, with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            tick();
            apply_stimulus(4'($urandom_range(0, 15)), 16'($urandom));
            req_b = 4'($urandom_range(0, 15));
            din_b = 16'($urandom);
            if ($urandom_range(0, 39) == 0) reset_pulse();
        end

        // Longer guard period: 7-cycle spacing, 6 cycles of grant each.
        apply_stimulus(4'b0000, 16'h0000);
        req_b = 4'b0011;
        din_b = 16'h00C5;
        tick();
        reset_pulse();
        wait_ld(1, ok);
        check_output("hold5_first_owner", int'(owner_b), 0);
        check_output("hold5_first_pin",   int'(pin_b),   'h5);
        gcount = 0;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            if (gnt_b != 0) gcount++;
        end
        tick();
        check_output("hold5_spacing",  int'(ld_b),    1);
        check_output("hold5_owner2",   int'(owner_b), 1);
        check_output("hold5_gnt_len",  gcount,        6);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
